color_route_filter: RTL
=======================

COLOR_ROUTE_FILTER -- requirements
Module: color_route_filter

Interface
REQ-001 SHALL have parameter DATA_W, default 10, meaning bits per colour channel.
REQ-002 SHALL have parameter CYCLE_FRAMES, default 60, meaning frames per auto-cycle step (legal range 1..1023).
REQ-003 SHALL have port iCLK, input, 1, meaning the single clock; all state on rising edge.
REQ-004 SHALL have port iRST, input, 1, meaning reset: asynchronous, active-high.
REQ-005 SHALL have port iMODE, input, 4, meaning requested mode; sampled only on iSOF.
REQ-006 SHALL have port iSOF, input, 1, meaning one-cycle start-of-frame pulse; independent of iDVAL.
REQ-007 SHALL have port iDVAL, input, 1, meaning input pixel valid.
REQ-008 SHALL have ports iRed, iGreen, iBlue, input, DATA_W each, meaning input pixel channels.
REQ-009 SHALL have ports oRed, oGreen, oBlue, output, DATA_W each, meaning filtered pixel channels.
REQ-010 SHALL have port oDVAL, output, 1, meaning output pixel valid.
REQ-011 SHALL have port oMODE, output, 4, meaning currently active mode.
REQ-012 SHALL have port oPHASE, output, 3, meaning current auto-cycle permutation index 0..5.

Function
REQ-013 SHALL define permutations: p0 (R,G,B); p1 (R,B,G); p2 (B,G,R); p3 (B,R,G); p4 (G,B,R); p5 (G,R,B); tuple order is (oRed,oGreen,oBlue).
REQ-014 SHALL implement modes: 0 passthrough; 1..5 fixed permutation p1..p5; 6 grayscale; 7 invert; 8 auto-cycle; 9..15 passthrough.
REQ-015 SHALL compute grayscale as Y=(R+2G+B)>>2 in DATA_W+2 bits, truncated to DATA_W, driven on all three outputs.
REQ-016 SHALL compute invert per channel as (2^DATA_W-1)-c.
REQ-017 SHALL apply auto-cycle by using permutation p[phase].
REQ-018 SHALL update the active mode from iMODE only in an iSOF cycle; iMODE changes mid-frame SHALL have no effect.
REQ-019 SHALL process a pixel with iDVAL and iSOF in the same cycle using the newly latched mode and phase.
REQ-020 SHALL, in mode 8, increment the frame counter on each iSOF; at CYCLE_FRAMES-1 plus iSOF it SHALL clear the counter and advance phase, wrapping 5->0.
REQ-021 SHALL clear the counter and phase to 0 on an iSOF entering mode 8 from another mode; SHALL hold them in other modes.
REQ-022 SHALL have a fixed latency of 2 cycles: oDVAL(t+2)=iDVAL(t); no backpressure.
REQ-023 SHALL update pipeline data registers only when their stage valid is 1; otherwise outputs hold last value.
REQ-024 SHALL update oMODE and oPHASE in the cycle after iSOF.

Reset
REQ-025 SHALL, when iRST is asserted, immediately clear oRed, oGreen, oBlue, oDVAL, oMODE, oPHASE, the frame counter and all pipeline valids to 0.
REQ-026 SHALL discard in-flight pixels on reset mid-stream; after release, the first oDVAL SHALL appear 2 cycles after the first iDVAL.

Structure
REQ-027 SHALL provide package color_route_pkg holding mode constants (MODE_PASS..MODE_AUTO), the 3-bit permutation index type and NUM_PERM=6.
REQ-028 SHALL implement the combinational mode/permutation datapath as sub-module color_route_mux; control (mode, phase, counter) and the two pipeline stages SHALL live in the top module.

Verification
REQ-029 SHALL cover: iSOF with iMODE=3, pixel R=0x3FF G=0x155 B=0x0AA -> 2 cycles later oRed=0x0AA, oGreen=0x3FF, oBlue=0x155, oDVAL=1.
REQ-030 SHALL cover: active mode 0, iMODE=7 without iSOF -> outputs unchanged from passthrough; after next iSOF, R=0 -> oRed=0x3FF.
REQ-031 SHALL cover: mode 6, R=100 G=200 B=300 -> all outputs 200; R=G=B=0x3FF -> all outputs 0x3FF.
REQ-032 SHALL cover: CYCLE_FRAMES=2, mode 8, 14 iSOF pulses -> oPHASE sequence 0,0,1,1,2,2,3,3,4,4,5,5,0,0.
REQ-033 SHALL cover: iRST asserted mid-frame with valid pixels in flight -> oDVAL=0 and oMODE=0 with no clock edge; no stale pixel after release.
REQ-034 SHALL cover: iDVAL toggling 1,0,1 -> oDVAL 1,0,1 delayed 2 cycles; data held during the gap.

Source files
------------

// File: rtl/color_route_pkg.sv
// Shared constants and types for the colour routing filter.
// Covers mode encodings, the permutation index type and the phase-advance helper.
package color_route_pkg;

    localparam int unsigned MODE_W   = 4;
    localparam int unsigned PERM_W   = 3;
    localparam int unsigned NUM_PERM = 6;
    localparam int unsigned CNT_W    = 10;

    typedef logic [MODE_W-1:0] mode_t;
    typedef logic [PERM_W-1:0] perm_idx_t;

    localparam mode_t MODE_PASS = 4'd0;
    localparam mode_t MODE_P1   = 4'd1;
    localparam mode_t MODE_P5   = 4'd5;
    localparam mode_t MODE_GRAY = 4'd6;
    localparam mode_t MODE_INV  = 4'd7;
    localparam mode_t MODE_AUTO = 4'd8;

    // Next auto-cycle permutation, wrapping after the last one.
    function automatic perm_idx_t next_perm(input perm_idx_t p);
        return (p == perm_idx_t'(NUM_PERM - 1)) ? '0 : p + perm_idx_t'(1);
    endfunction

endpackage

// File: rtl/color_route_mux.sv
// Combinational channel router.
// Applies the permutation, grayscale or invert transform for one pixel.
module color_route_mux
    import color_route_pkg::*;
#(
    parameter int unsigned DATA_W = 10
) (
    input  mode_t             i_mode,
    input  perm_idx_t         i_phase,
    input  logic [DATA_W-1:0] i_red,
    input  logic [DATA_W-1:0] i_green,
    input  logic [DATA_W-1:0] i_blue,
    output logic [DATA_W-1:0] o_red_c,
    output logic [DATA_W-1:0] o_green_c,
    output logic [DATA_W-1:0] o_blue_c
);

    logic [DATA_W+1:0] w_luma_sum;
    perm_idx_t         w_perm;

    assign w_luma_sum = (DATA_W+2)'(i_red) + (DATA_W+2)'({i_green, 1'b0}) + (DATA_W+2)'(i_blue);

    // Fixed modes pick their own permutation; auto-cycle follows the phase.
    always_comb begin
        w_perm = '0;
        if (i_mode >= MODE_P1 && i_mode <= MODE_P5) begin
            w_perm = perm_idx_t'(i_mode);
        end else if (i_mode == MODE_AUTO) begin
            w_perm = i_phase;
        end
    end

    always_comb begin
        o_red_c   = i_red;
        o_green_c = i_green;
        o_blue_c  = i_blue;
        if (i_mode == MODE_GRAY) begin
            o_red_c   = w_luma_sum[DATA_W+1:2];
            o_green_c = w_luma_sum[DATA_W+1:2];
            o_blue_c  = w_luma_sum[DATA_W+1:2];
        end else if (i_mode == MODE_INV) begin
            o_red_c   = ~i_red;
            o_green_c = ~i_green;
            o_blue_c  = ~i_blue;
        end else begin
            case (w_perm)
                3'd1: begin o_green_c = i_blue;  o_blue_c  = i_green; end
                3'd2: begin o_red_c   = i_blue;  o_blue_c  = i_red;   end
                3'd3: begin o_red_c   = i_blue;  o_green_c = i_red;   o_blue_c = i_green; end
                3'd4: begin o_red_c   = i_green; o_green_c = i_blue;  o_blue_c = i_red;   end
                3'd5: begin o_red_c   = i_green; o_green_c = i_red;   end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/color_route_filter.sv
// Frame-synchronous colour routing filter with a two-stage pixel pipeline.
// Mode and auto-cycle phase change only on start-of-frame.
module color_route_filter
    import color_route_pkg::*;
#(
    parameter int unsigned DATA_W       = 10,
    parameter int unsigned CYCLE_FRAMES = 60
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic [3:0]        iMODE,
    input  logic              iSOF,
    input  logic              iDVAL,
    input  logic [DATA_W-1:0] iRed,
    input  logic [DATA_W-1:0] iGreen,
    input  logic [DATA_W-1:0] iBlue,
    output logic [DATA_W-1:0] oRed,
    output logic [DATA_W-1:0] oGreen,
    output logic [DATA_W-1:0] oBlue,
    output logic              oDVAL,
    output logic [3:0]        oMODE,
    output logic [2:0]        oPHASE
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLE_FRAMES - 1);

    mode_t             r_mode,  w_mode_nxt;
    perm_idx_t         r_phase, w_phase_nxt;
    logic [CNT_W-1:0]  r_cnt,   w_cnt_nxt;

    logic              r_s1_v;
    mode_t             r_s1_mode;
    perm_idx_t         r_s1_phase;
    logic [DATA_W-1:0] r_s1_red, r_s1_green, r_s1_blue;

    logic              r_s2_v;
    logic [DATA_W-1:0] r_s2_red, r_s2_green, r_s2_blue;
    logic [DATA_W-1:0] w_mux_red, w_mux_green, w_mux_blue;

    // Frame-boundary control: latch mode, run the auto-cycle frame counter.
    always_comb begin
        w_mode_nxt  = r_mode;
        w_phase_nxt = r_phase;
        w_cnt_nxt   = r_cnt;
        if (iSOF) begin
            w_mode_nxt = mode_t'(iMODE);
            if (mode_t'(iMODE) == MODE_AUTO) begin
                if (r_mode != MODE_AUTO) begin
                    w_cnt_nxt   = '0;
                    w_phase_nxt = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_phase_nxt = next_perm(r_phase);
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_mode  <= '0;
            r_phase <= '0;
            r_cnt   <= '0;
        end else begin
            r_mode  <= w_mode_nxt;
            r_phase <= w_phase_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Stage 1 captures the pixel with the mode/phase in force for it.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_s1_v     <= 1'b0;
            r_s1_mode  <= '0;
            r_s1_phase <= '0;
            r_s1_red   <= '0;
            r_s1_green <= '0;
            r_s1_blue  <= '0;
        end else begin
            r_s1_v <= iDVAL;
            if (iDVAL) begin
                r_s1_mode  <= w_mode_nxt;
                r_s1_phase <= w_phase_nxt;
                r_s1_red   <= iRed;
                r_s1_green <= iGreen;
                r_s1_blue  <= iBlue;
            end
        end
    end

    color_route_mux #(
        .DATA_W (DATA_W)
    ) u_mux (
        .i_mode    (r_s1_mode),
        .i_phase   (r_s1_phase),
        .i_red     (r_s1_red),
        .i_green   (r_s1_green),
        .i_blue    (r_s1_blue),
        .o_red_c   (w_mux_red),
        .o_green_c (w_mux_green),
        .o_blue_c  (w_mux_blue)
    );

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_s2_v     <= 1'b0;
            r_s2_red   <= '0;
            r_s2_green <= '0;
            r_s2_blue  <= '0;
        end else begin
            r_s2_v <= r_s1_v;
            if (r_s1_v) begin
                r_s2_red   <= w_mux_red;
                r_s2_green <= w_mux_green;
                r_s2_blue  <= w_mux_blue;
            end
        end
    end

    assign oRed   = r_s2_red;
    assign oGreen = r_s2_green;
    assign oBlue  = r_s2_blue;
    assign oDVAL  = r_s2_v;
    assign oMODE  = r_mode;
    assign oPHASE = r_phase;

endmodule
